// File: rtl/key_matrix_pkg.sv
// Shared constants and coordinate helpers for the 4x4 key matrix scanner.
// The coordinate type matches the LED matrix dot driver's x/y format.
package key_matrix_pkg;
    localparam int         KM_N         = 4;
    localparam int         KM_KEYS      = 16;
    localparam logic [3:0] KM_COL_RESET = 4'b1110;

    typedef logic [3:0] coord_t;

    // Flat key index: bit y*4 + x of the matrix vectors.
    function automatic logic [3:0] km_index(input coord_t x, input coord_t y);
        return {y[1:0], x[1:0]};
    endfunction
endpackage

// File: rtl/km_frame_debouncer.sv
// Full-matrix frame debouncer: a frame must repeat DEB_FRAMES times in a row
// before the debounced state follows it; reports newly pressed keys on update.
module km_frame_debouncer
    import key_matrix_pkg::*;
#(
    parameter int DEB_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KM_KEYS-1:0] raw,
    input  logic               frame_end,
    output logic [KM_KEYS-1:0] pressed,
    output logic [KM_KEYS-1:0] new_mask
);
    localparam logic [3:0] DEB_TARGET = 4'(DEB_FRAMES);

    logic [KM_KEYS-1:0] prev_raw_r;
    logic [KM_KEYS-1:0] pressed_r;
    logic [3:0]         stable_cnt_r;
    logic [3:0]         cnt_next_s;
    logic               update_s;

    // Saturating stability count and press mask for the frame being closed.
    always_comb begin
        cnt_next_s = 4'd0;
        update_s   = 1'b0;
        new_mask   = {KM_KEYS{1'b0}};
        if (raw == prev_raw_r) begin
            cnt_next_s = (stable_cnt_r >= DEB_TARGET) ? DEB_TARGET : stable_cnt_r + 4'd1;
        end else begin
            cnt_next_s = 4'd0;
        end
        update_s = frame_end && (cnt_next_s == DEB_TARGET);
        new_mask = update_s ? (raw & ~pressed_r) : {KM_KEYS{1'b0}};
    end

    // Frame history and debounced state, advanced only at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_raw_r   <= {KM_KEYS{1'b0}};
            pressed_r    <= {KM_KEYS{1'b0}};
            stable_cnt_r <= 4'd0;
        end else if (frame_end) begin
            stable_cnt_r <= cnt_next_s;
            prev_raw_r   <= raw;
            if (update_s) begin
                pressed_r <= raw;
            end
        end
    end

    assign pressed = pressed_r;
endmodule

// File: rtl/key_matrix_scanner.sv
// 4x4 active-low key matrix scanner: column drive, row sampling, frame
// debouncing and one-pulse-per-press (x, y) event emission.
module key_matrix_scanner
    import key_matrix_pkg::*;
#(
    parameter int TICK_DIV   = 12000,
    parameter int DEB_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] pressed,
    output logic        key_valid,
    output logic [3:0]  x,
    output logic [3:0]  y
);
    localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0]   div_r;
    logic [1:0]         col_idx_r;
    logic [3:0]         col_r;
    logic [KM_KEYS-1:0] raw_r;
    logic [KM_KEYS-1:0] raw_next_s;
    logic [KM_KEYS-1:0] pending_r;
    logic [KM_KEYS-1:0] new_mask_s;
    logic [KM_KEYS-1:0] clear_s;
    logic [KM_KEYS-1:0] pressed_s;
    logic [3:0]         emit_idx_s;
    logic               emit_any_s;
    logic               tick_s;
    logic               frame_end_s;
    logic               kv_r;
    coord_t             x_r;
    coord_t             y_r;

    assign tick_s      = (div_r == DIV_LAST);
    assign frame_end_s = tick_s && (col_idx_r == 2'd3);

    // Raw matrix including this tick's column sample (sense lines are active-low).
    always_comb begin
        raw_next_s = raw_r;
        for (int yy = 0; yy < KM_N; yy++) begin
            raw_next_s[km_index({2'b00, col_idx_r}, 4'(yy))] =
                tick_s ? ~row[yy] : raw_r[km_index({2'b00, col_idx_r}, 4'(yy))];
        end
    end

    // Lowest pending key index wins the next event slot.
    always_comb begin
        emit_idx_s = 4'd0;
        emit_any_s = |pending_r;
        for (int i = KM_KEYS - 1; i >= 0; i--) begin
            emit_idx_s = pending_r[i] ? 4'(i) : emit_idx_s;
        end
        clear_s = emit_any_s ? (16'h0001 << emit_idx_s) : 16'h0000;
    end

    // Tick divider, column rotation and raw sample capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r     <= {DIV_W{1'b0}};
            col_idx_r <= 2'd0;
            col_r     <= KM_COL_RESET;
            raw_r     <= {KM_KEYS{1'b0}};
        end else begin
            raw_r <= raw_next_s;
            if (tick_s) begin
                div_r     <= {DIV_W{1'b0}};
                col_idx_r <= col_idx_r + 2'd1;
                col_r     <= {col_r[2:0], col_r[3]};
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    km_frame_debouncer #(
        .DEB_FRAMES(DEB_FRAMES)
    ) u_debouncer (
        .clk      (clk),
        .rst      (rst),
        .raw      (raw_next_s),
        .frame_end(frame_end_s),
        .pressed  (pressed_s),
        .new_mask (new_mask_s)
    );

    // Pending press set and event outputs; x/y hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= {KM_KEYS{1'b0}};
            kv_r      <= 1'b0;
            x_r       <= 4'd0;
            y_r       <= 4'd0;
        end else begin
            pending_r <= (pending_r & ~clear_s) | new_mask_s;
            kv_r      <= emit_any_s;
            if (emit_any_s) begin
                x_r <= {2'b00, emit_idx_s[1:0]};
                y_r <= {2'b00, emit_idx_s[3:2]};
            end
        end
    end

    assign col       = col_r;
    assign pressed   = pressed_s;
    assign key_valid = kv_r;
    assign x         = x_r;
    assign y         = y_r;
endmodule

// File: tb/tb_key_matrix_scanner.sv
// Self-checking bench for key_matrix_scanner: a keypad model drives the rows,
// a frame-history reference model predicts every output each cycle.
module tb_key_matrix_scanner;
    localparam int TD  = 4;
    localparam int DEB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] pressed;
    logic        key_valid;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [15:0] keys = 16'h0000;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_cyc = 0;
    logic [15:0] m_raw = 16'h0000;
    logic [15:0] m_hist[$];
    logic [15:0] m_pressed = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    logic        m_kv = 1'b0;
    logic [3:0]  m_x = 4'd0;
    logic [3:0]  m_y = 4'd0;

    // observed events
    int ev_x[$];
    int ev_y[$];
    int ev_t[$];
    int cyc = 0;

    key_matrix_scanner #(.TICK_DIV(TD), .DEB_FRAMES(DEB)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .pressed(pressed),
        .key_valid(key_valid), .x(x), .y(y)
    );

    always #5 clk = ~clk;

    // Physical keypad: a closed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int ci = 0; ci < 4; ci++) begin
            for (int yy = 0; yy < 4; yy++) begin
                if (col[ci] == 1'b0 && keys[yy*4+ci]) row[yy] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference model, using the key state before the edge.
    task automatic model_step();
        logic [15:0] clr;
        logic [15:0] newm;
        int          c;
        int          idx;
        bit          same;
        clr  = 16'h0000;
        newm = 16'h0000;
        idx  = 0;
        if (rst) begin
            m_cyc = 0; m_raw = 16'h0000; m_hist = '{16'h0000};
            m_pressed = 16'h0000; m_pend = 16'h0000;
            m_kv = 1'b0; m_x = 4'd0; m_y = 4'd0;
        end else begin
            if (m_pend != 16'h0000) begin
                for (int i = 15; i >= 0; i--) if (m_pend[i]) idx = i;
                m_kv = 1'b1; m_x = 4'(idx % 4); m_y = 4'(idx / 4); clr[idx] = 1'b1;
            end else begin
                m_kv = 1'b0;
            end
            if (m_cyc % TD == TD - 1) begin
                c = (m_cyc / TD) % 4;
                for (int yy = 0; yy < 4; yy++) m_raw[yy*4+c] = keys[yy*4+c];
                if (c == 3) begin
                    m_hist.push_back(m_raw);
                    if (m_hist.size() > DEB + 1) void'(m_hist.pop_front());
                    same = (m_hist.size() == DEB + 1);
                    foreach (m_hist[k]) if (m_hist[k] != m_raw) same = 1'b0;
                    if (same) begin
                        newm = m_raw & ~m_pressed;
                        m_pressed = m_raw;
                    end
                end
            end
            m_pend = (m_pend & ~clr) | newm;
            m_cyc++;
        end
    endtask

    task automatic run(input int n);
        logic [3:0] exp_col;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            cyc++;
            exp_col = ~(4'b0001 << ((m_cyc / TD) % 4));
            check_eq("col", {28'h0, col}, {28'h0, exp_col});
            check_eq("pressed", {16'h0, pressed}, {16'h0, m_pressed});
            check_eq("key_valid", {31'h0, key_valid}, {31'h0, m_kv});
            check_eq("x", {28'h0, x}, {28'h0, m_x});
            check_eq("y", {28'h0, y}, {28'h0, m_y});
            if (key_valid === 1'b1) begin
                ev_x.push_back(int'(x)); ev_y.push_back(int'(y)); ev_t.push_back(cyc);
            end
        end
    endtask

    task automatic ev_clear();
        ev_x.delete(); ev_y.delete(); ev_t.delete();
    endtask

    // Advance to just after a frame end so all columns see the same frame.
    task automatic align_frame();
        for (int i = 0; i < 4 * TD; i++) begin
            if (m_cyc % (4 * TD) == 0) break;
            run(1);
        end
    endtask

    initial begin
        rst  = 1'b1;
        keys = 16'h0000;
        run(3);
        check_eq("rst_col", {28'h0, col}, 32'hE);
        check_eq("rst_pressed", {16'h0, pressed}, 32'h0);
        check_eq("rst_kv", {31'h0, key_valid}, 32'h0);
        check_eq("rst_xy", {24'h0, x, y}, 32'h0);
        rst = 1'b0;
        run(4 * TD * 2 + $urandom_range(0, 7));

        // single press at (1,2)
        ev_clear();
        keys = 16'h0200;
        run(64);
        check_eq("single_count", ev_x.size(), 1);
        if (ev_x.size() == 1) begin
            check_eq("single_x", ev_x[0], 1);
            check_eq("single_y", ev_y[0], 2);
        end
        check_eq("single_pressed", {16'h0, pressed}, 32'h0200);

        // release: bit 9 clears with no event
        ev_clear();
        keys = 16'h0000;
        run(64);
        check_eq("release_bit9", {31'h0, pressed[9]}, 32'h0);
        check_eq("release_count", ev_x.size(), 0);

        // bounce: toggle every frame for 5 frames, then hold
        run($urandom_range(0, 15));
        ev_clear();
        for (int f = 0; f < 5; f++) begin
            keys = (f % 2 == 0) ? 16'h0200 : 16'h0000;
            run(4 * TD);
        end
        check_eq("bounce_quiet", ev_x.size(), 0);
        run(64);
        check_eq("bounce_count", ev_x.size(), 1);

        // simultaneous press of (0,0), (3,0), (2,3)
        keys = 16'h0000;
        run(64);
        align_frame();
        ev_clear();
        keys = 16'h4009;
        run(64);
        check_eq("simul_count", ev_x.size(), 3);
        if (ev_x.size() == 3) begin
            check_eq("simul_xy0", ev_x[0] * 4 + ev_y[0], 0);
            check_eq("simul_xy1", ev_x[1] * 4 + ev_y[1], 12);
            check_eq("simul_xy2", ev_x[2] * 4 + ev_y[2], 11);
            check_eq("simul_back2back", ev_t[2] - ev_t[0], 2);
        end

        // reset between first and second of three queued events
        keys = 16'h0000;
        run(64);
        align_frame();
        ev_clear();
        keys = 16'h4009;
        for (int i = 0; i < 80; i++) begin
            if (ev_x.size() > 0) break;
            run(1);
        end
        check_eq("midrst_first_seen", ev_x.size(), 1);
        rst  = 1'b1;
        keys = 16'h0000;
        run(1);
        check_eq("midrst_kv", {31'h0, key_valid}, 32'h0);
        check_eq("midrst_pressed", {16'h0, pressed}, 32'h0);
        check_eq("midrst_col", {28'h0, col}, 32'hE);
        rst = 1'b0;
        run(48);
        check_eq("midrst_no_more", ev_x.size(), 1);

        // random key patterns held for random durations
        for (int it = 0; it < 40; it++) begin
            keys = 16'($urandom & $urandom & $urandom);
            run($urandom_range(4, 48));
        end
        keys = 16'h0000;
        run(64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
